// File: rtl/instr_encoder_if.sv
// Producer-side instruction stream, control pulses and instruction-memory write port of the loader.
// The master modport is the producer/controller and the slave modport is the encoder.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic                  finish;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            op_kind;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [15:0]           imm;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  done;
  logic                  err;

  modport master (
    output start, finish, in_valid, op_kind, rs, rt, rd, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, done, err
  );

  modport slave (
    input  start, finish, in_valid, op_kind, rs, rt, rd, imm,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes decoded instructions into MIPS words and writes them to imem from address 0; write lands 1 cycle after accept.
// in_ready only in LOAD with no start/finish this cycle; FULL holds off the producer until the next start.
module instr_encoder #(
  parameter int ADDR_WIDTH = 6
) (
  input logic             clk,
  input logic             reset,
  instr_encoder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  full_q, full_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  in_ready;
  logic                  xfer;
  logic                  op_ok;

  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'h20};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'h22};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'h24};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'h25};
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'h2A};
      4'd5:    w = {6'b100011, rs, rt, imm};
      4'd6:    w = {6'b101011, rs, rt, imm};
      4'd7:    w = {6'b000100, rs, rt, imm};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign in_ready = (state_q == LOAD) && !bus.start && !bus.finish;
  assign xfer     = bus.in_valid && in_ready;
  assign op_ok    = !bus.op_kind[3];

  // The write pointer is the low bits of count: both only advance on real writes.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    full_d  = full_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (bus.start) begin
      state_d = LOAD;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else if (bus.finish) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (xfer) begin
      if (op_ok) begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_WIDTH-1:0];
        wdata_d = encode(bus.op_kind, bus.rs, bus.rt, bus.rd, bus.imm);
        count_d = count_q + ONE_CNT;
        if (count_q == LAST_CNT) begin
          full_d  = 1'b1;
          state_d = FULL;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Drives a 64-word and a 4-word loader with identical stimulus and checks both against a transaction-level model.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        st, fin, vld;
  logic [3:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  instr_encoder_if #(.ADDR_WIDTH(6)) bus6 ();
  instr_encoder_if #(.ADDR_WIDTH(2)) bus2 ();

  assign bus6.start = st;  assign bus6.finish = fin; assign bus6.in_valid = vld;
  assign bus6.op_kind = op; assign bus6.rs = rs; assign bus6.rt = rt; assign bus6.rd = rd; assign bus6.imm = imm;
  assign bus2.start = st;  assign bus2.finish = fin; assign bus2.in_valid = vld;
  assign bus2.op_kind = op; assign bus2.rs = rs; assign bus2.rt = rt; assign bus2.rd = rd; assign bus2.imm = imm;

  instr_encoder #(.ADDR_WIDTH(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6));
  instr_encoder #(.ADDR_WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    bit          active;
    bit          full;
    bit          err;
    bit          done;
    bit          we;
    int          count;
    int          addr;
    logic [31:0] wdata;
  } model_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          full;
  } wentry_t;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  model_t  m6, m2;
  wentry_t wlog6[$];
  wentry_t wlog2[$];
  int      nchk = 0;
  int      nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic model_t mzero();
    model_t z;
    z.active = 0; z.full = 0; z.err = 0; z.done = 0; z.we = 0;
    z.count = 0; z.addr = 0; z.wdata = '0;
    return z;
  endfunction

  function automatic logic [31:0] ref_word(input int o, input int s, input int t, input int d, input int im);
    int     funct [5];
    int     opc [3];
    longint w;
    funct = '{32, 34, 36, 37, 42};
    opc   = '{35, 43, 4};
    if (o < 5) w = longint'(s) * (1 << 21) + longint'(t) * (1 << 16) + longint'(d) * (1 << 11) + funct[o];
    else       w = longint'(opc[o-5]) * (64'd1 << 26) + longint'(s) * (1 << 21) + longint'(t) * (1 << 16) + im;
    return w[31:0];
  endfunction

  function automatic bit mready(input model_t m);
    return m.active && !m.full && !st && !fin;
  endfunction

  function automatic model_t mstep(input model_t m, input int depth);
    model_t n;
    n = m;
    n.we = 0;
    n.done = 0;
    if (st) begin
      n.active = 1; n.full = 0; n.count = 0; n.err = 0;
    end else if (fin) begin
      n.active = 0; n.done = 1;
    end else if (vld && mready(m)) begin
      if (op < 8) begin
        n.we = 1;
        n.addr = m.count;
        n.wdata = ref_word(int'(op), int'(rs), int'(rt), int'(rd), int'(imm));
        n.count = m.count + 1;
        if (n.count == depth) n.full = 1;
      end else begin
        n.err = 1;
      end
    end
    return n;
  endfunction

  task automatic cmp(input string tag, input model_t m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] cnt, input logic full,
                     input logic done, input logic err);
    chk({tag, ".imem_we"}, 32'(we), 32'(m.we));
    chk({tag, ".imem_addr"}, addr, 32'(m.addr));
    chk({tag, ".imem_wdata"}, wdata, m.wdata);
    chk({tag, ".count"}, cnt, 32'(m.count));
    chk({tag, ".full"}, 32'(full), 32'(m.full));
    chk({tag, ".done"}, 32'(done), 32'(m.done));
    chk({tag, ".err"}, 32'(err), 32'(m.err));
  endtask

  // One clock: in_ready checked mid-cycle, registered outputs checked just after the edge.
  task automatic cycle();
    wentry_t e;
    #1;
    chk("dut6.in_ready", 32'(bus6.in_ready), 32'(mready(m6)));
    chk("dut2.in_ready", 32'(bus2.in_ready), 32'(mready(m2)));
    @(posedge clk);
    if (reset) begin
      m6 = mzero(); m2 = mzero();
    end else begin
      m6 = mstep(m6, 64); m2 = mstep(m2, 4);
    end
    #1;
    cmp("dut6", m6, bus6.imem_we, 32'(bus6.imem_addr), bus6.imem_wdata, 32'(bus6.count), bus6.full, bus6.done, bus6.err);
    cmp("dut2", m2, bus2.imem_we, 32'(bus2.imem_addr), bus2.imem_wdata, 32'(bus2.count), bus2.full, bus2.done, bus2.err);
    if (bus6.imem_we === 1'b1) begin
      e.addr = 32'(bus6.imem_addr); e.data = bus6.imem_wdata; e.full = bus6.full;
      wlog6.push_back(e);
    end
    if (bus2.imem_we === 1'b1) begin
      e.addr = 32'(bus2.imem_addr); e.data = bus2.imem_wdata; e.full = bus2.full;
      wlog2.push_back(e);
    end
  endtask

  task automatic pulse_start();
    st = 1'b1;
    cycle();
    st = 1'b0;
    wlog6.delete();
    wlog2.delete();
  endtask

  task automatic set_add(input logic [4:0] d);
    op = 4'd0; rs = 5'd1; rt = 5'd2; rd = d; imm = 16'h0;
  endtask

  vec_t vecs [5];
  bit   hold;

  initial begin
    st = 0; fin = 0; vld = 0; op = 0; rs = 0; rt = 0; rd = 0; imm = 0;
    m6 = mzero(); m2 = mzero();

    repeat (2) cycle();
    chk("reset.in_ready", 32'(bus6.in_ready), 32'd0);
    chk("reset.imem_wdata", bus6.imem_wdata, 32'd0);
    chk("reset.count", 32'(bus6.count), 32'd0);
    reset = 1'b0;
    cycle();

    // Stall: valid held through IDLE and the start cycle, then accepted once.
    set_add(5'd3);
    vld = 1'b1;
    repeat (3) cycle();
    chk("stall.no_write_idle", 32'(wlog6.size()), 32'd0);
    pulse_start();
    chk("stall.no_write_start", 32'(bus6.imem_we), 32'd0);
    cycle();
    chk("stall.first_we", 32'(bus6.imem_we), 32'd1);
    chk("stall.first_addr", 32'(bus6.imem_addr), 32'd0);
    chk("stall.first_data", bus6.imem_wdata, 32'h00221820);
    vld = 1'b0;
    repeat (2) cycle();
    chk("stall.single_write", 32'(wlog6.size()), 32'd1);

    // Encoding sweep, back to back.
    vecs[0] = '{4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h00221820};
    vecs[1] = '{4'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 32'h00221822};
    vecs[2] = '{4'd5, 5'd9, 5'd8, 5'd0, 16'h0004, 32'h8D280004};
    vecs[3] = '{4'd6, 5'd9, 5'd8, 5'd0, 16'h0008, 32'hAD280008};
    vecs[4] = '{4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 32'h1022FFFF};
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      op = vecs[i].op; rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd; imm = vecs[i].imm;
      vld = 1'b1;
      cycle();
    end
    vld = 1'b0;
    cycle();
    chk("sweep.nwrites", 32'(wlog6.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wlog6.size()) begin
        chk($sformatf("sweep.addr%0d", i), 32'(wlog6[i].addr), 32'(i));
        chk($sformatf("sweep.data%0d", i), wlog6[i].data, vecs[i].exp);
      end
    end
    chk("sweep.count", 32'(bus6.count), 32'd5);

    // Invalid op between two ADDs.
    pulse_start();
    set_add(5'd3); vld = 1'b1;
    cycle();
    op = 4'd9;
    #1 chk("inv.ready_for_bad", 32'(bus6.in_ready), 32'd1);
    cycle();
    set_add(5'd4);
    cycle();
    vld = 1'b0;
    cycle();
    chk("inv.err", 32'(bus6.err), 32'd1);
    chk("inv.nwrites", 32'(wlog6.size()), 32'd2);
    if (wlog6.size() == 2) begin
      chk("inv.addr1", 32'(wlog6[1].addr), 32'd1);
      chk("inv.data1", wlog6[1].data, 32'h00222020);
    end
    chk("inv.count", 32'(bus6.count), 32'd2);
    pulse_start();
    chk("inv.err_cleared", 32'(bus6.err), 32'd0);

    // Fill the 4-word instance.
    pulse_start();
    set_add(5'd7); vld = 1'b1;
    repeat (6) cycle();
    vld = 1'b0;
    cycle();
    chk("full.nwrites", 32'(wlog2.size()), 32'd4);
    if (wlog2.size() == 4) begin
      chk("full.last_addr", 32'(wlog2[3].addr), 32'd3);
      chk("full.with_last_write", 32'(wlog2[3].full), 32'd1);
      chk("full.not_early", 32'(wlog2[2].full), 32'd0);
    end
    chk("full.flag", 32'(bus2.full), 32'd1);
    chk("full.count", 32'(bus2.count), 32'd4);
    #1 chk("full.in_ready", 32'(bus2.in_ready), 32'd0);

    // finish with valid, start with finish, finish behind an in-flight write.
    pulse_start();
    set_add(5'd3); vld = 1'b1; fin = 1'b1;
    cycle();
    fin = 1'b0; vld = 1'b0;
    chk("coll.fin_done", 32'(bus6.done), 32'd1);
    chk("coll.fin_no_write", 32'(bus6.imem_we), 32'd0);
    cycle();
    chk("coll.done_one_cycle", 32'(bus6.done), 32'd0);
    st = 1'b1; fin = 1'b1;
    cycle();
    st = 1'b0; fin = 1'b0;
    chk("coll.startfin_no_done", 32'(bus6.done), 32'd0);
    #1 chk("coll.startfin_load", 32'(bus6.in_ready), 32'd1);
    vld = 1'b1;
    cycle();
    vld = 1'b0; fin = 1'b1;
    #1 chk("coll.inflight_we", 32'(bus6.imem_we), 32'd1);
    cycle();
    fin = 1'b0;
    chk("coll.inflight_done", 32'(bus6.done), 32'd1);

    // Asynchronous reset with a write in flight.
    pulse_start();
    set_add(5'd3); vld = 1'b1;
    repeat (4) cycle();
    vld = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset.we", 32'(bus6.imem_we), 32'd0);
    chk("areset.addr", 32'(bus6.imem_addr), 32'd0);
    chk("areset.data", bus6.imem_wdata, 32'd0);
    chk("areset.count", 32'(bus6.count), 32'd0);
    chk("areset.in_ready", 32'(bus6.in_ready), 32'd0);
    m6 = mzero(); m2 = mzero();
    cycle();
    reset = 1'b0;
    vld = 1'b1;
    cycle();
    chk("areset.idle_no_write", 32'(bus6.imem_we), 32'd0);
    pulse_start();
    cycle();
    vld = 1'b0;
    chk("areset.restart_we", 32'(bus6.imem_we), 32'd1);
    chk("areset.restart_addr", 32'(bus6.imem_addr), 32'd0);
    cycle();

    // Random traffic against the model; fields held while stalled.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        m6 = mzero(); m2 = mzero();
        cycle();
        reset = 1'b0;
      end else begin
        st  = ($urandom_range(0, 99) < 4);
        fin = ($urandom_range(0, 99) < 4);
        if (!hold) begin
          vld = ($urandom_range(0, 99) < 60);
          op  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
          rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
        end
        hold = vld && !mready(m6);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program loader for the single-cycle MIPS core. It accepts decoded instruction fields (operation kind, register numbers, immediate) over a valid/ready handshake. Each accepted instruction is encoded into a 32-bit MIPS word, and the words are written sequentially into instruction memory starting at address 0. It produces exactly the opcode/funct encodings the core's control unit decodes: R-type ADD/SUB/AND/OR/SLT, LW, SW, BEQ.

## Interface
Parameters:
- ADDR_WIDTH, 6, word-address width of instruction memory (depth 2^ADDR_WIDTH).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces all state and outputs to reset values.
- start  input  1  one-cycle pulse: clear pointer, count and err, enter LOAD.
- finish  input  1  one-cycle pulse: leave LOAD/FULL, pulse done.
- in_valid  input  1  producer has an instruction.
- in_ready  output  1  encoder accepts this cycle.
- op_kind  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8-15 invalid.
- rs, rt, rd  input  5 each  register fields (rd ignored for LW/SW/BEQ).
- imm  input  16  immediate/offset (ignored for R-type).
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  encoded instruction.
- count  output  ADDR_WIDTH+1  words written since last start.
- full  output  1  memory filled, no further acceptance.
- done  output  1  one-cycle pulse after finish.
- err  output  1  sticky: an invalid op_kind was accepted since last start.

## Operation
- States: IDLE, LOAD, FULL. Reset state is IDLE.
- Transitions:
  - IDLE -> LOAD on start.
  - LOAD -> FULL on the write of address 2^ADDR_WIDTH-1.
  - LOAD/FULL -> IDLE on finish.
  - start in any state -> LOAD, with wr_ptr=0, count=0, err=0, full=0.
- in_ready = (state==LOAD) && !start && !finish. This is combinational from registered state and the control inputs.
- Handshake: a transfer occurs on an edge where in_valid && in_ready. The producer must hold its fields stable while in_valid && !in_ready.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}, with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - LW: {6'b100011, rs, rt, imm}.
  - SW: {6'b101011, rs, rt, imm}.
  - BEQ: {6'b000100, rs, rt, imm}.
- Valid transfer:
  - Drives imem_we=1, imem_addr=wr_ptr and imem_wdata=encoding.
  - Then wr_ptr+1 and count+1.
  - wr_ptr wraps to 0 only via start, never by overflow; FULL blocks the next write.
- Invalid op_kind transfer:
  - The word is consumed (handshake completes) but not written: imem_we=0, wr_ptr and count unchanged.
  - err is set and stays set until start or reset.
- Priority: reset > start > finish > handshake. If start and finish coincide, start wins and done does not pulse.
- Reset values: state IDLE; in_ready 0; imem_we 0; imem_addr 0; imem_wdata 0; count 0; full 0; done 0; err 0.

## Timing
- Latency: imem_we, imem_addr and imem_wdata are registered and asserted in the cycle after the accepting edge, for exactly one cycle.
- Back-to-back transfers give one write per cycle, at consecutive addresses.
- imem_wdata holds its last value when imem_we=0.
- count updates on the same edge as the write registers, so it equals the number of imem_we pulses issued.
- full rises on the edge that registers the write to the last address, i.e. together with that imem_we. in_ready is 0 from that cycle onward.
- done is high for exactly the one cycle after the finish edge.
- finish in IDLE still pulses done. A write already registered when finish arrives still completes (imem_we in the finish+1 cycle).
- Reset asserted mid-LOAD clears everything immediately, including an in-flight imem_we. After reset, start is required before further loading.

## Test plan
- Encoding sweep: start, then ADD rs=1 rt=2 rd=3, SUB (same regs), LW rs=9 rt=8 imm=4, SW rs=9 rt=8 imm=8, BEQ rs=1 rt=2 imm=0xFFFF.
  - Required writes: addr 0..4 with 0x00221820, 0x00221822, 0x8D280004, 0xAD280008, 0x1022FFFF.
  - count=5.
- Backpressure/stall: in_valid held high across IDLE and then start.
  - No imem_we before start.
  - First write at addr 0 in the cycle after the first accepting edge.
  - Fields held unchanged during stall are written once only.
- Invalid op: op_kind=9 between two ADDs.
  - Handshake completes; err=1.
  - Writes only at addr 0 and 1; count=2.
  - A following start clears err.
- Full: ADDR_WIDTH=2, stream 5 valid ADDs.
  - Writes at addr 0..3; full=1 with the addr-3 write; in_ready=0 afterwards.
  - The 5th word is never accepted; count=4.
- Control collisions:
  - finish together with in_valid: no transfer; done pulses next cycle.
  - start together with finish: LOAD entered, no done.
- Async reset: assert reset mid-stream after 3 writes.
  - All outputs drop to reset values without waiting for a clock edge.
  - After release and start, the next write goes to addr 0.
